pcie_x1_top_sync_rcv: RTL and testbench
=======================================

PCIE_X1_TOP_SYNC_RCV -- requirements
Module: pcie_x1_top_sync_rcv

Interface
REQ-001: Parameter WIDTH, default 8, bundled data width in bits.
REQ-002: Parameter SYNC_STAGES, default 2, depth of the req synchronizer chain; legal range 2..4.
REQ-003: Parameter TO_CYC, default 256, cycles in ACK before a timeout error is flagged; legal range 2..65535.
REQ-004: s_clk  input  1  single block clock; every flop is clocked on its rising edge.
REQ-005: rst_n  input  1  reset, synchronous to s_clk and active-low.
REQ-006: req_async  input  1  four-phase request level from the foreign clock domain.
REQ-007: data_async  input  WIDTH  bundled data from the sender, stable whenever req_async is high.
REQ-008: ack  output  1  four-phase acknowledge level returned to the sender, driven directly from a flop.
REQ-009: out_data  output  WIDTH  captured payload.
REQ-010: out_valid  output  1  out_data holds an unconsumed word.
REQ-011: out_ready  input  1  consumer accepts out_data when both out_valid and out_ready are high.
REQ-012: xfer_cnt  output  16  count of captured words.
REQ-013: err_timeout  output  1  sticky flag: req stayed high too long after ack was raised.
REQ-014: err_clr  input  1  clears err_timeout.

Function
REQ-015: req_async SHALL pass through a SYNC_STAGES-flop chain; req_s is the last stage; no other logic SHALL sample req_async.
REQ-016: data_async SHALL be sampled only on the capture edge and never synchronized.
REQ-017: The FSM SHALL have two states, IDLE (ack=0) and ACK (ack=1).
REQ-018: Capture condition in IDLE: req_s=1 and (out_valid=0 or out_ready=1).
REQ-019: On capture: out_data<=data_async, out_valid<=1, ack<=1, xfer_cnt<=xfer_cnt+1 (wraps 0xFFFF->0x0000), state<=ACK.
REQ-020: In IDLE with req_s=1, out_valid=1 and out_ready=0, the FSM SHALL stall (no capture, ack stays 0) until the capture condition holds.
REQ-021: In ACK with req_s=0, the block SHALL set ack<=0 and state<=IDLE; a new capture SHALL NOT occur on that same edge.
REQ-022: In ACK with req_s=1, state and ack SHALL hold.
REQ-023: Output handshake: when out_valid=1, out_ready=1 and no capture occurs on that edge, out_valid<=0; a simultaneous consume and capture SHALL leave out_valid=1 with the new data.
REQ-024: out_data SHALL stay stable while out_valid=1 and not consumed.
REQ-025: Latency: if req_async is first sampled high at edge N, then ack, out_valid and out_data SHALL update at edge N+SYNC_STAGES (capture condition assumed true).
REQ-026: ack fall latency: if req_async is first sampled low at edge M, ack SHALL be 0 after edge M+SYNC_STAGES.
REQ-027: Timeout counter behaviour:
- clears on entry to ACK;
- increments each cycle in ACK while req_s=1;
- saturates at TO_CYC.
REQ-028: When the timeout counter reaches TO_CYC, err_timeout SHALL be set; the FSM stays in ACK and waits for req_s=0.
REQ-029: err_clr=1 SHALL clear err_timeout on the next edge; a simultaneous set SHALL win.
REQ-030: If req_s is already 1 in IDLE after reset, the block SHALL treat it as a new request.

Reset
REQ-031: When rst_n=0 at a rising edge of s_clk, on that edge:
- sync chain <= 0;
- state <= IDLE;
- ack = 0, out_valid = 0, out_data = 0, xfer_cnt = 0, err_timeout = 0;
- timeout counter <= 0.
REQ-032: Reset asserted mid-transfer SHALL abort that transfer and discard any unconsumed word; after release, the block SHALL follow REQ-030.

Verification
REQ-033: SYNC_STAGES=2, out_ready=1. Drive data_async=0xA5 and raise req_async before edge 10 -> at edge 12: ack=1, out_valid=1, out_data=0xA5, xfer_cnt=1. Then drop req -> ack=0 two edges after it is sampled low.
REQ-034: Back-pressure with out_ready=0 and a word pending. Raise a second req -> ack stays 0 and out_data unchanged. Raise out_ready -> capture on that edge, out_valid stays 1 with the new data.
REQ-035: Hold req high 300 cycles after ack rises (TO_CYC=256) -> err_timeout=1 at the 256th ACK cycle. Pulse err_clr -> cleared on the next edge. Assert err_clr in the same cycle as the set -> err_timeout stays 1.
REQ-036: Preload xfer_cnt to 0xFFFF via 65535 transfers, then one more transfer -> xfer_cnt=0x0000.
REQ-037: Assert rst_n=0 while in ACK with out_valid=1 -> after the edge, all outputs are 0. Release with req_async still high -> recapture after SYNC_STAGES+1 edges.
REQ-038: Randomised four-phase sender on an asynchronous clock, 10k words -> every word is received exactly once in order, and ack never changes while req_s is unchanged.

Source files
------------

// File: rtl/pcie_x1_top_sync_rcv.sv
`timescale 1ns/100ps
// pcie_x1_top_sync_rcv
// Receiving half of a four-phase req/ack bundled-data crossing. The request
// level is synchronized into s_clk. The data bus is not synchronized; the
// sender holds it stable while req is high, so it is sampled once, on the
// capture edge. A one-word output register with a valid/ready handshake
// presents the payload to the local consumer.
//
// Ports
//   s_clk       in   block clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req_async   in   request level from the foreign domain
//   data_async  in   bundled payload, stable while req_async is high
//   ack         out  acknowledge level back to the sender (flop output)
//   out_data    out  captured payload
//   out_valid   out  out_data holds an unconsumed word
//   out_ready   in   consumer accepts out_data when out_valid is also high
//   xfer_cnt    out  number of captured words, wraps at 16 bits
//   err_timeout out  sticky: req stayed high TO_CYC cycles after ack rose
//   err_clr     in   clears err_timeout; a simultaneous set wins
module pcie_x1_top_sync_rcv #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TO_CYC      = 256
) (
    input  logic             s_clk,
    input  logic             rst_n,
    input  logic             req_async,
    input  logic [WIDTH-1:0] data_async,
    output logic             ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      xfer_cnt,
    output logic             err_timeout,
    input  logic             err_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [15:0] TO_LIM = 16'(TO_CYC);

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] req_meta_p;
    logic                   req_s;
    logic                   capture;
    logic                   consume;
    logic                   err_set;
    logic [15:0]            to_cnt_q;
    logic [15:0]            to_cnt_d;

    // ---- synchronizer stage: the only flops that see req_async ----
    always_ff @(posedge s_clk) begin
        if (!rst_n) begin
            req_meta_p <= '0;
        end else begin
            req_meta_p <= {req_meta_p[SYNC_STAGES-2:0], req_async};
        end
    end

    assign req_s = req_meta_p[SYNC_STAGES-1];

    // ---- handshake FSM: next state, capture and timeout decisions ----
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        capture  = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending word blocks capture unless it leaves on this edge.
                if (req_s && (!out_valid || out_ready)) begin
                    capture  = 1'b1;
                    state_d  = ACK;
                    to_cnt_d = '0;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                end else if (to_cnt_q != TO_LIM) begin
                    to_cnt_d = to_cnt_q + 16'd1;
                    // Flag only on the edge the counter reaches the limit.
                    err_set  = (to_cnt_q == TO_LIM - 16'd1);
                end
            end
        endcase
    end

    // A capture refills the register, so it overrides a consume.
    assign consume = out_valid && out_ready && !capture;

    // ---- register stage: state, ack, payload, counters ----
    always_ff @(posedge s_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ack         <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            xfer_cnt    <= '0;
            err_timeout <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ack      <= (state_d == ACK);
            to_cnt_q <= to_cnt_d;
            if (capture) begin
                out_data  <= data_async;
                out_valid <= 1'b1;
                xfer_cnt  <= xfer_cnt + 16'd1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
            if (err_set) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcie_x1_top_sync_rcv.sv
`timescale 1ns/100ps
module tb_pcie_x1_top_sync_rcv;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TO_CYC      = 256;
    localparam int N_RAND      = 1500;
    localparam int RAND_BOUND  = 60000;

    logic             s_clk;
    logic             a_clk;
    logic             rst_n;
    logic             req_async;
    logic [WIDTH-1:0] data_async;
    logic             ack;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      xfer_cnt;
    logic             err_timeout;
    logic             err_clr;

    int n_chk  = 0;
    int n_pass = 0;

    // random-phase bookkeeping
    logic [WIDTH-1:0] exp_words [N_RAND];
    logic [1:0]       m_sync;
    int               rcv;
    int               viol;
    int               cyc;
    int               snd_to;
    logic             snd_done;
    logic             ack_prev;
    logic             rs_prev;
    logic             vld_prev;
    logic             rdy_prev;
    logic             rdy;
    logic [WIDTH-1:0] data_prev;

    pcie_x1_top_sync_rcv #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TO_CYC      (TO_CYC)
    ) dut (
        .s_clk       (s_clk),
        .rst_n       (rst_n),
        .req_async   (req_async),
        .data_async  (data_async),
        .ack         (ack),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .xfer_cnt    (xfer_cnt),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    // s_clk rising edges at 5+10m; a_clk rising edges at 4.5+7j never meet them.
    initial begin
        s_clk = 1'b0;
        forever #5 s_clk = ~s_clk;
    end

    initial begin
        a_clk = 1'b0;
        #1;
        forever #3.5 a_clk = ~a_clk;
    end

    // Reference copy of the request synchronizer (two stages).
    always @(posedge s_clk) begin
        if (!rst_n) m_sync <= 2'b00;
        else        m_sync <= {m_sync[0], req_async};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (ack !== lvl && n < 40) begin
            @(negedge s_clk);
            n++;
        end
        chk(tag, 32'(ack), 32'(lvl));
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        data_async = d;
        req_async  = 1'b1;
        wait_ack(1'b1, "send_ack_rise");
        req_async  = 1'b0;
        wait_ack(1'b0, "send_ack_fall");
    endtask

    initial begin
        rst_n      = 1'b0;
        req_async  = 1'b0;
        data_async = '0;
        out_ready  = 1'b1;
        err_clr    = 1'b0;
        snd_done   = 1'b0;
        repeat (3) @(negedge s_clk);
        chk("rst_ack",   32'(ack),         32'h0);
        chk("rst_valid", 32'(out_valid),   32'h0);
        chk("rst_data",  32'(out_data),    32'h0);
        chk("rst_cnt",   32'(xfer_cnt),    32'h0);
        chk("rst_err",   32'(err_timeout), 32'h0);
        rst_n = 1'b1;
        @(negedge s_clk);

        // Basic transfer and latency, consumer always ready.
        data_async = 8'hA5;
        req_async  = 1'b1;
        @(negedge s_clk);
        chk("lat_edge_n",    32'(ack), 32'h0);
        @(negedge s_clk);
        chk("lat_edge_n1",   32'(ack), 32'h0);
        @(negedge s_clk);
        chk("lat_ack",       32'(ack),       32'h1);
        chk("lat_valid",     32'(out_valid), 32'h1);
        chk("lat_data",      32'(out_data),  32'hA5);
        chk("lat_cnt",       32'(xfer_cnt),  32'h1);
        req_async = 1'b0;
        @(negedge s_clk);
        chk("consume_valid", 32'(out_valid), 32'h0);
        chk("fall_edge_m",   32'(ack),       32'h1);
        @(negedge s_clk);
        chk("fall_edge_m1",  32'(ack),       32'h1);
        @(negedge s_clk);
        chk("fall_edge_m2",  32'(ack),       32'h0);

        // Back-pressure: a pending word stalls the next request.
        out_ready = 1'b0;
        send(8'h3C);
        chk("bp_pend_valid", 32'(out_valid), 32'h1);
        chk("bp_pend_data",  32'(out_data),  32'h3C);
        data_async = 8'h5A;
        req_async  = 1'b1;
        repeat (6) @(negedge s_clk);
        chk("bp_stall_ack",  32'(ack),       32'h0);
        chk("bp_stall_data", 32'(out_data),  32'h3C);
        chk("bp_stall_vld",  32'(out_valid), 32'h1);
        chk("bp_stall_cnt",  32'(xfer_cnt),  32'h2);
        out_ready = 1'b1;
        @(negedge s_clk);
        chk("bp_cap_ack",    32'(ack),       32'h1);
        chk("bp_cap_valid",  32'(out_valid), 32'h1);
        chk("bp_cap_data",   32'(out_data),  32'h5A);
        chk("bp_cap_cnt",    32'(xfer_cnt),  32'h3);
        req_async = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");
        chk("bp_drained",    32'(out_valid), 32'h0);

        // Timeout: set on the TO_CYC-th ACK cycle, then cleared by err_clr.
        data_async = 8'h11;
        req_async  = 1'b1;
        wait_ack(1'b1, "to_ack_rise");
        repeat (TO_CYC - 1) @(negedge s_clk);
        chk("to_before",     32'(err_timeout), 32'h0);
        @(negedge s_clk);
        chk("to_set",        32'(err_timeout), 32'h1);
        chk("to_ack_hold",   32'(ack),         32'h1);
        err_clr = 1'b1;
        @(negedge s_clk);
        chk("to_clr",        32'(err_timeout), 32'h0);
        err_clr = 1'b0;
        repeat (50) @(negedge s_clk);
        chk("to_saturated",  32'(err_timeout), 32'h0);
        chk("to_ack_still",  32'(ack),         32'h1);
        req_async = 1'b0;
        wait_ack(1'b0, "to_ack_fall");

        // Timeout set and err_clr on the same edge: set wins.
        data_async = 8'h22;
        req_async  = 1'b1;
        wait_ack(1'b1, "to2_ack_rise");
        repeat (TO_CYC - 1) @(negedge s_clk);
        chk("to2_before",    32'(err_timeout), 32'h0);
        err_clr = 1'b1;
        @(negedge s_clk);
        chk("to2_set_wins",  32'(err_timeout), 32'h1);
        err_clr = 1'b0;
        @(negedge s_clk);
        chk("to2_sticky",    32'(err_timeout), 32'h1);
        req_async = 1'b0;
        wait_ack(1'b0, "to2_ack_fall");
        chk("to2_cnt",       32'(xfer_cnt),    32'h5);

        // Reset in ACK with a pending word, released while req is still high.
        out_ready  = 1'b0;
        data_async = 8'h77;
        req_async  = 1'b1;
        wait_ack(1'b1, "mrst_ack_rise");
        chk("mrst_pend",     32'(out_valid), 32'h1);
        rst_n = 1'b0;
        @(negedge s_clk);
        chk("mrst_ack",      32'(ack),         32'h0);
        chk("mrst_valid",    32'(out_valid),   32'h0);
        chk("mrst_data",     32'(out_data),    32'h0);
        chk("mrst_cnt",      32'(xfer_cnt),    32'h0);
        chk("mrst_err",      32'(err_timeout), 32'h0);
        rst_n = 1'b1;
        @(negedge s_clk);
        chk("mrst_rel_e1",   32'(ack), 32'h0);
        @(negedge s_clk);
        chk("mrst_rel_e2",   32'(ack), 32'h0);
        @(negedge s_clk);
        chk("mrst_recap",    32'(ack),       32'h1);
        chk("mrst_rc_data",  32'(out_data),  32'h77);
        chk("mrst_rc_cnt",   32'(xfer_cnt),  32'h1);
        req_async = 1'b0;
        out_ready = 1'b1;
        wait_ack(1'b0, "mrst_ack_fall");

        // Counter wrap: the counter is preset to 0xFFFF instead of walking
        // 65535 transfers, then one real transfer must wrap it.
        force dut.xfer_cnt = 16'hFFFF;
        @(negedge s_clk);
        release dut.xfer_cnt;
        @(negedge s_clk);
        data_async = 8'hEE;
        req_async  = 1'b1;
        wait_ack(1'b1, "wrap_ack_rise");
        chk("wrap_cnt",      32'(xfer_cnt), 32'h0);
        chk("wrap_data",     32'(out_data), 32'hEE);
        req_async = 1'b0;
        wait_ack(1'b0, "wrap_ack_fall");
        repeat (2) @(negedge s_clk);

        // Random four-phase sender on a_clk against a random-ready consumer.
        rcv = 0; viol = 0; cyc = 0; snd_to = 0;
        ack_prev = ack; rs_prev = m_sync[1];
        vld_prev = 1'b0; rdy_prev = 1'b0; data_prev = '0;
        fork
            begin : sender
                for (int i = 0; i < N_RAND; i++) begin
                    int n;
                    @(posedge a_clk);
                    data_async   = WIDTH'($urandom);
                    exp_words[i] = data_async;
                    req_async    = 1'b1;
                    n = 0;
                    while (ack !== 1'b1 && n < 400) begin
                        @(posedge a_clk);
                        n++;
                    end
                    if (ack !== 1'b1) begin
                        snd_to++;
                        break;
                    end
                    req_async = 1'b0;
                    n = 0;
                    while (ack !== 1'b0 && n < 400) begin
                        @(posedge a_clk);
                        n++;
                    end
                    if (ack !== 1'b0) begin
                        snd_to++;
                        break;
                    end
                end
                snd_done = 1'b1;
            end
            begin : consumer
                while (rcv < N_RAND && cyc < RAND_BOUND && snd_to == 0) begin
                    @(negedge s_clk);
                    cyc++;
                    if (ack !== ack_prev && ack !== rs_prev) viol++;
                    if (vld_prev && !rdy_prev && (out_valid !== 1'b1 || out_data !== data_prev)) viol++;
                    ack_prev  = ack;
                    rs_prev   = m_sync[1];
                    rdy       = ($urandom_range(0, 3) != 0);
                    out_ready = rdy;
                    if (out_valid && rdy) begin
                        chk("rand_word", 32'(out_data), 32'(exp_words[rcv]));
                        rcv++;
                    end
                    vld_prev  = out_valid;
                    rdy_prev  = rdy;
                    data_prev = out_data;
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) @(negedge s_clk);
        chk("rand_sender_to", 32'(snd_to),   32'h0);
        chk("rand_done",      32'(snd_done), 32'h1);
        chk("rand_count",     32'(rcv),      32'(N_RAND));
        chk("rand_viol",      32'(viol),     32'h0);
        chk("rand_xfer_cnt",  32'(xfer_cnt), 32'(N_RAND));
        chk("rand_idle_vld",  32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
